// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump master: FSM state encoding
// and the default geometry of the dumped register window.
package regfile_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Highest architectural register index that can be dumped (x15).
    localparam int unsigned NUM_REGS       = 15;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump master. Walks FIRST_REG..LAST_REG through a shared read
// port (one register per granted slot), streams each captured value out on a
// valid/ready interface, and snoops the write port to flag dumps that are not
// a consistent snapshot.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned FIRST_REG  = 1,
    parameter int unsigned LAST_REG   = NUM_REGS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_start,
    input  logic                  I_abort,
    output logic [ADDR_WIDTH-1:0] O_rs,
    input  logic [DATA_WIDTH-1:0] I_rdata,
    input  logic                  I_grant,
    input  logic                  I_regwen,
    input  logic [ADDR_WIDTH-1:0] I_rd,
    output logic                  O_valid,
    input  logic                  I_ready,
    output logic [DATA_WIDTH-1:0] O_data,
    output logic [ADDR_WIDTH-1:0] O_idx,
    output logic                  O_last,
    output logic                  O_busy,
    output logic                  O_done,
    output logic                  O_stale
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);
    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [ADDR_WIDTH-1:0] idx_r;
    logic [ADDR_WIDTH-1:0] idx_nxt_s;
    logic                  start_acc_s;
    logic                  abort_s;
    logic                  capture_s;
    logic                  stale_hit_s;

    // Qualify requests: start only counts from IDLE without a simultaneous abort, abort only while busy.
    always_comb begin
        start_acc_s = 1'b0;
        abort_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            start_acc_s = I_start & ~I_abort;
        end else begin
            abort_s = I_abort;
        end
    end

    // Next-state and index sequencing; abort overrides grant/ready in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        capture_s   = 1'b0;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        state_nxt_s = ST_REQ;
                        idx_nxt_s   = FIRST_IDX;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (I_grant) begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_OUT;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_OUT: begin
                    if (I_ready) begin
                        if (idx_r == LAST_IDX) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_REQ;
                            idx_nxt_s   = idx_r + IDX_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_OUT;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // A write hits the snapshot if it targets a register already captured, or the one captured on this edge.
    always_comb begin
        stale_hit_s = 1'b0;
        if ((state_r != ST_IDLE) && I_regwen && (I_rd != IDX_ZERO)) begin
            if ((I_rd >= FIRST_IDX) && (I_rd < idx_r)) begin
                stale_hit_s = 1'b1;
            end else if ((I_rd == idx_r) &&
                         ((state_r == ST_OUT) || (state_r == ST_DONE) || capture_s)) begin
                stale_hit_s = 1'b1;
            end else begin
                stale_hit_s = 1'b0;
            end
        end else begin
            stale_hit_s = 1'b0;
        end
    end

    // State, walk index and the sticky stale flag (cleared only by an accepted start).
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_r <= ST_IDLE;
            idx_r   <= FIRST_IDX;
            O_stale <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            if (start_acc_s) begin
                O_stale <= 1'b0;
            end else if (stale_hit_s) begin
                O_stale <= 1'b1;
            end else begin
                O_stale <= O_stale;
            end
        end
    end

    // Status and read-port outputs registered from the next state so they line up with the state register.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            O_valid <= 1'b0;
            O_last  <= 1'b0;
            O_busy  <= 1'b0;
            O_done  <= 1'b0;
            O_rs    <= IDX_ZERO;
        end else begin
            O_valid <= (state_nxt_s == ST_OUT);
            O_last  <= (state_nxt_s == ST_OUT) && (idx_nxt_s == LAST_IDX);
            O_busy  <= (state_nxt_s != ST_IDLE);
            O_done  <= (state_nxt_s == ST_DONE);
            O_rs    <= (state_nxt_s == ST_REQ) ? idx_nxt_s : IDX_ZERO;
        end
    end

    // Capture register: samples the read port on a granted slot, holds it while the beat is pending.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            O_data <= {DATA_WIDTH{1'b0}};
            O_idx  <= IDX_ZERO;
        end else if (capture_s) begin
            O_data <= I_rdata;
            O_idx  <= idx_r;
        end else begin
            O_data <= O_data;
            O_idx  <= O_idx;
        end
    end

endmodule
